// File: rtl/pixel_compositor_if.sv
// Pixel bus between the layer index generators, sprite ROMs, palette host
// and the compositor; the compositor side uses the slave modport.
interface pixel_compositor_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank_n;
  logic [17:0] kirbyindex;
  logic [17:0] areaindex;
  logic [17:0] enemyindex;
  logic [16:0] backindex;
  logic [16:0] starindex;
  logic        star_active;
  logic        enemy_active;
  logic [17:0] kirby_addr;
  logic [17:0] area_addr;
  logic [17:0] enemy_addr;
  logic [16:0] back_addr;
  logic [16:0] star_addr;
  logic [3:0]  kirby_data;
  logic [3:0]  area_data;
  logic [3:0]  enemy_data;
  logic [3:0]  back_data;
  logic [3:0]  star_data;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic [7:0]  Red;
  logic [7:0]  Green;
  logic [7:0]  Blue;
  logic        blank_n_out;
  logic        frame_done;
  logic        hit_kirby_enemy;
  logic        hit_star_enemy;

  modport master (
    output DrawX, DrawY, blank_n,
    output kirbyindex, areaindex, enemyindex,
    output backindex, starindex,
    output star_active, enemy_active,
    input  kirby_addr, area_addr, enemy_addr,
    input  back_addr, star_addr,
    output kirby_data, area_data, enemy_data,
    output back_data, star_data,
    output pal_we, pal_addr, pal_wdata,
    input  Red, Green, Blue, blank_n_out,
    input  frame_done,
    input  hit_kirby_enemy, hit_star_enemy
  );

  modport slave (
    input  DrawX, DrawY, blank_n,
    input  kirbyindex, areaindex, enemyindex,
    input  backindex, starindex,
    input  star_active, enemy_active,
    output kirby_addr, area_addr, enemy_addr,
    output back_addr, star_addr,
    input  kirby_data, area_data, enemy_data,
    input  back_data, star_data,
    input  pal_we, pal_addr, pal_wdata,
    output Red, Green, Blue, blank_n_out,
    output frame_done,
    output hit_kirby_enemy, hit_star_enemy
  );
endinterface

// File: rtl/pixel_compositor.sv
// Three-stage layer compositor: ROM address, code capture, palette/RGB,
// with per-frame latched Kirby/enemy and star/enemy collision flags.
module pixel_compositor #(
  parameter logic [9:0]  X_MIN      = 10'd203,
  parameter logic [9:0]  X_MAX      = 10'd436,
  parameter logic [9:0]  Y_MIN      = 10'd152,
  parameter logic [9:0]  Y_MAX      = 10'd328,
  parameter logic [3:0]  TRANS_CODE = 4'h0,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input logic Clk,
  input logic Reset,
  pixel_compositor_if.slave bus
);

  logic        w_win;
  logic        w_sof;
  logic [3:0]  w_pres;

  logic        r1_win, r1_bn, r1_sof;
  logic [3:0]  r1_pres;

  logic        r2_win, r2_bn, r2_sof;
  logic [3:0]  r2_pres;
  logic [3:0]  r2_s, r2_k, r2_e, r2_a, r2_b;

  logic [23:0] r_pal [16];
  logic        r_st_ke, r_st_se;

  logic        w_os, w_ok, w_oe, w_oa;
  logic        w_act, w_ke, w_se;
  logic [3:0]  w_code;
  logic [23:0] w_rgb;

  assign w_win = (bus.DrawX >= X_MIN) && (bus.DrawX < X_MAX) &&
                 (bus.DrawY >= Y_MIN) && (bus.DrawY < Y_MAX);
  assign w_sof = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);

  // present flags ordered {star, kirby, enemy, area}
  assign w_pres = {
    (bus.starindex != '0) && bus.star_active,
    bus.kirbyindex != '0,
    (bus.enemyindex != '0) && bus.enemy_active,
    bus.areaindex != '0
  };

  assign w_os = r2_pres[3] && (r2_s != TRANS_CODE);
  assign w_ok = r2_pres[2] && (r2_k != TRANS_CODE);
  assign w_oe = r2_pres[1] && (r2_e != TRANS_CODE);
  assign w_oa = r2_pres[0] && (r2_a != TRANS_CODE);

  assign w_act = r2_win && r2_bn;
  assign w_ke  = w_act && w_ok && w_oe;
  assign w_se  = w_act && w_os && w_oe;

  always_comb begin
    w_code = r2_b;
    if (w_os)      w_code = r2_s;
    else if (w_ok) w_code = r2_k;
    else if (w_oe) w_code = r2_e;
    else if (w_oa) w_code = r2_a;
  end

  always_comb begin
    w_rgb = r_pal[w_code];
    if (!r2_win)     w_rgb = BORDER_RGB;
    else if (!r2_bn) w_rgb = 24'h000000;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.kirby_addr <= '0;
      bus.area_addr  <= '0;
      bus.enemy_addr <= '0;
      bus.back_addr  <= '0;
      bus.star_addr  <= '0;
      r1_win  <= 1'b0;
      r1_bn   <= 1'b0;
      r1_sof  <= 1'b0;
      r1_pres <= '0;
    end else begin
      bus.kirby_addr <= bus.kirbyindex;
      bus.area_addr  <= bus.areaindex;
      bus.enemy_addr <= bus.enemyindex;
      bus.back_addr  <= bus.backindex;
      bus.star_addr  <= bus.starindex;
      r1_win  <= w_win;
      r1_bn   <= bus.blank_n;
      r1_sof  <= w_sof;
      r1_pres <= w_pres;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r2_win  <= 1'b0;
      r2_bn   <= 1'b0;
      r2_sof  <= 1'b0;
      r2_pres <= '0;
      r2_s    <= '0;
      r2_k    <= '0;
      r2_e    <= '0;
      r2_a    <= '0;
      r2_b    <= '0;
    end else begin
      r2_win  <= r1_win;
      r2_bn   <= r1_bn;
      r2_sof  <= r1_sof;
      r2_pres <= r1_pres;
      r2_s    <= bus.star_data;
      r2_k    <= bus.kirby_data;
      r2_e    <= bus.enemy_data;
      r2_a    <= bus.area_data;
      r2_b    <= bus.back_data;
    end
  end

  // writes land at the edge, so the S3 read this cycle sees the old entry
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) r_pal[i] <= '0;
    end else if (bus.pal_we) begin
      r_pal[bus.pal_addr] <= bus.pal_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.Red         <= '0;
      bus.Green       <= '0;
      bus.Blue        <= '0;
      bus.blank_n_out <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.hit_kirby_enemy <= 1'b0;
      bus.hit_star_enemy  <= 1'b0;
      r_st_ke <= 1'b0;
      r_st_se <= 1'b0;
    end else begin
      bus.Red         <= w_rgb[23:16];
      bus.Green       <= w_rgb[15:8];
      bus.Blue        <= w_rgb[7:0];
      bus.blank_n_out <= r2_bn;
      bus.frame_done  <= r2_sof;
      if (r2_sof) begin
        bus.hit_kirby_enemy <= r_st_ke;
        bus.hit_star_enemy  <= r_st_se;
        r_st_ke <= w_ke;
        r_st_se <= w_se;
      end else begin
        r_st_ke <= r_st_ke | w_ke;
        r_st_se <= r_st_se | w_se;
      end
    end
  end

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed-vector bench for pixel_compositor with a rule-level model of
// window, priority, palette timing and per-frame collision latching.
module tb_pixel_compositor;

  typedef struct {
    int x; int y; bit bn;
    int ki; int kc; int ei; int ec; bit ea;
    int si; int sc; bit sa; int ai; int ac;
    int bi; int bc;
    bit we; int wa; logic [23:0] wd;
    bit lit; logic [23:0] lrgb;
    bit lith; bit lke; bit lse;
  } vec_t;

  logic clk;
  logic rst;
  pixel_compositor_if bus ();

  pixel_compositor dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t q[$];
  logic [23:0] mpal [16];
  bit st_ke, st_se, h_ke, h_se;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic vec_t px(int x, int y, bit bn);
    vec_t v;
    v = '{default: 0};
    v.x = x; v.y = y; v.bn = bn;
    return v;
  endfunction

  function automatic vec_t get(int base, int len, int j);
    if (j < 0 || j >= len) return px(1, 1, 1'b0);
    return q[base + j];
  endfunction

  function automatic void model(vec_t v, output logic [23:0] rgb,
                                output bit ke, output bit se);
    bit win, act, os, ok, oe, oa;
    int code;
    win = v.x >= 203 && v.x < 436 && v.y >= 152 && v.y < 328;
    os = v.si != 0 && v.sa && v.sc != 0;
    ok = v.ki != 0 && v.kc != 0;
    oe = v.ei != 0 && v.ea && v.ec != 0;
    oa = v.ai != 0 && v.ac != 0;
    code = os ? v.sc : ok ? v.kc : oe ? v.ec : oa ? v.ac : v.bc;
    if (!win)       rgb = 24'h000000;
    else if (!v.bn) rgb = 24'h000000;
    else            rgb = mpal[code];
    act = win && v.bn;
    ke = act && ok && oe;
    se = act && os && oe;
  endfunction

  task automatic drive(vec_t c, vec_t p);
    bus.DrawX        = 10'(c.x);
    bus.DrawY        = 10'(c.y);
    bus.blank_n      = c.bn;
    bus.kirbyindex   = 18'(c.ki);
    bus.areaindex    = 18'(c.ai);
    bus.enemyindex   = 18'(c.ei);
    bus.backindex    = 17'(c.bi);
    bus.starindex    = 17'(c.si);
    bus.star_active  = c.sa;
    bus.enemy_active = c.ea;
    bus.pal_we       = c.we;
    bus.pal_addr     = 4'(c.wa);
    bus.pal_wdata    = c.wd;
    bus.kirby_data   = 4'(p.kc);
    bus.area_data    = 4'(p.ac);
    bus.enemy_data   = 4'(p.ec);
    bus.back_data    = 4'(p.bc);
    bus.star_data    = 4'(p.sc);
  endtask

  task automatic hold_reset(int n);
    vec_t v;
    v = px(300, 200, 1'b1);
    v.ki = 40; v.kc = 2; v.ei = 50; v.ec = 4; v.ea = 1'b1;
    v.bi = 3; v.bc = 5;
    @(negedge clk);
    rst = 1'b1;
    drive(v, v);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_rgb", {bus.Red, bus.Green, bus.Blue}, 0);
      chk("rst_bn", bus.blank_n_out, 0);
      chk("rst_fd", bus.frame_done, 0);
      chk("rst_hits", {bus.hit_kirby_enemy, bus.hit_star_enemy}, 0);
      chk("rst_addr", bus.kirby_addr, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(px(1, 1, 1'b0), px(1, 1, 1'b0));
    for (int i = 0; i < 16; i++) mpal[i] = 24'h0;
    st_ke = 0; st_se = 0; h_ke = 0; h_se = 0;
  endtask

  task automatic run_seq(int base, int len);
    vec_t c, p, o;
    logic [23:0] erg;
    bit ke, se, sof;
    for (int j = 0; j < len + 2; j++) begin
      @(negedge clk);
      c = get(base, len, j);
      p = get(base, len, j - 1);
      drive(c, p);
      @(posedge clk); #1;
      chk("kirby_addr", bus.kirby_addr, c.ki);
      chk("enemy_addr", bus.enemy_addr, c.ei);
      chk("area_addr",  bus.area_addr,  c.ai);
      chk("back_addr",  bus.back_addr,  c.bi);
      chk("star_addr",  bus.star_addr,  c.si);
      o = get(base, len, j - 2);
      model(o, erg, ke, se);
      sof = (o.x == 0 && o.y == 0);
      if (sof) begin
        h_ke = st_ke; h_se = st_se;
        st_ke = ke;   st_se = se;
      end else begin
        st_ke |= ke;  st_se |= se;
      end
      if (c.we) mpal[c.wa] = c.wd;
      chk("rgb", {bus.Red, bus.Green, bus.Blue}, erg);
      chk("blank_n_out", bus.blank_n_out, o.bn);
      chk("frame_done", bus.frame_done, sof);
      chk("hit_ke", bus.hit_kirby_enemy, h_ke);
      chk("hit_se", bus.hit_star_enemy, h_se);
      if (o.lit)
        chk("lit_rgb", {bus.Red, bus.Green, bus.Blue}, o.lrgb);
      if (o.lith)
        chk("lit_hits", {bus.hit_kirby_enemy, bus.hit_star_enemy},
            {o.lke, o.lse});
    end
  endtask

  task automatic add_w(int a, logic [23:0] d);
    vec_t v;
    v = px(1, 1, 1'b1);
    v.we = 1'b1; v.wa = a; v.wd = d;
    q.push_back(v);
  endtask

  task automatic add_bg(int x, int y, logic [23:0] l);
    vec_t v;
    v = px(x, y, 1'b1);
    v.bi = 9; v.bc = 7; v.lit = 1'b1; v.lrgb = l;
    q.push_back(v);
  endtask

  task automatic add_hit_sof(bit ke, bit se);
    vec_t v;
    v = px(0, 0, 1'b1);
    v.lith = 1'b1; v.lke = ke; v.lse = se;
    q.push_back(v);
  endtask

  int b1, l1, b2, l2, b3, l3;

  initial begin
    vec_t v;
    rst = 1'b1;
    drive(px(1, 1, 1'b0), px(1, 1, 1'b0));

    b1 = q.size();
    add_w(5, 24'h123456);
    add_w(9, 24'h0A0B0C);
    add_w(3, 24'h00FF00);
    add_w(2, 24'h222222);
    add_w(4, 24'h444444);
    add_w(7, 24'h777777);
    v = px(100, 200, 1'b1); v.bi = 3; v.bc = 5;
    v.lit = 1'b1; v.lrgb = 24'h000000; q.push_back(v);
    v = px(300, 200, 1'b1); v.bi = 123; v.bc = 5; v.kc = 9;
    v.lit = 1'b1; v.lrgb = 24'h123456; q.push_back(v);
    v = px(300, 200, 1'b1); v.bi = 123; v.bc = 5;
    v.ki = 40; v.kc = 3; v.si = 7; v.sc = 9; v.sa = 1'b1;
    v.lit = 1'b1; v.lrgb = 24'h0A0B0C; q.push_back(v);
    v.sc = 0; v.lrgb = 24'h00FF00; q.push_back(v);
    v.sc = 9; v.sa = 1'b0; q.push_back(v);
    v = px(300, 200, 1'b1); v.bi = 123; v.bc = 5;
    v.ei = 50; v.ec = 4; v.ea = 1'b1; v.ai = 60; v.ac = 2;
    v.lit = 1'b1; v.lrgb = 24'h444444; q.push_back(v);
    v.ea = 1'b0; v.lrgb = 24'h222222; q.push_back(v);
    v.ac = 0; v.lrgb = 24'h123456; q.push_back(v);
    add_bg(202, 200, 24'h000000);
    add_bg(203, 200, 24'h777777);
    add_bg(435, 200, 24'h777777);
    add_bg(436, 200, 24'h000000);
    add_bg(300, 151, 24'h000000);
    add_bg(300, 152, 24'h777777);
    add_bg(300, 327, 24'h777777);
    add_bg(300, 328, 24'h000000);
    v = px(300, 200, 1'b1); v.bi = 9; v.bc = 7;
    v.ki = 40; v.kc = 2; v.ei = 50; v.ec = 4; v.ea = 1'b1;
    v.lit = 1'b1; v.lrgb = 24'h222222; q.push_back(v);
    add_hit_sof(1'b1, 1'b0);
    v = px(300, 200, 1'b1); v.bi = 9; v.bc = 7;
    v.si = 7; v.sc = 9; v.sa = 1'b1; v.ei = 50; v.ec = 4; v.ea = 1'b1;
    v.lit = 1'b1; v.lrgb = 24'h0A0B0C; q.push_back(v);
    q.push_back(px(1, 1, 1'b1));
    add_hit_sof(1'b0, 1'b1);
    v = px(300, 200, 1'b0); v.bi = 9; v.bc = 7;
    v.ki = 40; v.kc = 2; v.ei = 50; v.ec = 4; v.ea = 1'b1;
    v.lit = 1'b1; v.lrgb = 24'h000000; q.push_back(v);
    add_hit_sof(1'b0, 1'b0);
    v = px(300, 200, 1'b1); v.bi = 9; v.bc = 7; v.ki = 40; v.kc = 3;
    v.lit = 1'b1; v.lrgb = 24'h00FF00; q.push_back(v);
    v.lrgb = 24'hFF0000; q.push_back(v);
    add_w(3, 24'hFF0000);
    l1 = q.size() - b1;

    b2 = q.size();
    v = px(300, 200, 1'b1); v.bi = 9; v.bc = 7;
    v.ki = 40; v.kc = 2; v.ei = 50; v.ec = 4; v.ea = 1'b1;
    q.push_back(v);
    q.push_back(px(1, 1, 1'b1));
    l2 = q.size() - b2;

    b3 = q.size();
    add_hit_sof(1'b0, 1'b0);
    q.push_back(px(1, 1, 1'b1));
    l3 = q.size() - b3;

    hold_reset(4);
    run_seq(b1, l1);
    run_seq(b2, l2);
    hold_reset(2);
    run_seq(b3, l3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pixel_compositor.md
Name: pixel_compositor

Overview:
- Downstream consumer of the per-layer index generators (Kirby, enemy, star, area, background).
- Registers each layer's index as a sprite-ROM address and receives the synchronous-ROM palette codes.
- Resolves layer priority and transparency, maps the winning code through a writable 16-entry palette and drives registered 24-bit RGB to the VGA output.
- Also detects per-pixel Kirby/enemy and star/enemy overlap and reports one latched collision result per frame to game logic.

Parameters:
- X_MIN, 203, first playfield column (inclusive).
- X_MAX, 436, playfield column bound (exclusive).
- Y_MIN, 152, first playfield row (inclusive).
- Y_MAX, 328, playfield row bound (exclusive).
- TRANS_CODE, 4'h0, palette code treated as transparent for sprite and area layers.
- BORDER_RGB, 24'h000000, colour outside the playfield window.

Ports:
- Clk  in  1  pixel clock
- Reset  in  1  synchronous, active-high reset
- DrawX, DrawY  in  10 each  current pixel coordinates
- blank_n  in  1  active-video qualifier for the current pixel
- kirbyindex, areaindex, enemyindex  in  18 each  layer indices (0 = layer absent)
- backindex, starindex  in  17 each  layer indices
- star_active, enemy_active  in  1 each  layer enables
- kirby_addr, area_addr, enemy_addr  out  18 each  registered ROM addresses
- back_addr, star_addr  out  17 each  registered ROM addresses
- kirby_data, area_data, enemy_data, back_data, star_data  in  4 each  ROM codes; valid one clock after the address is registered
- pal_we  in  1  palette write enable
- pal_addr  in  4  palette write address
- pal_wdata  in  24  palette write data {R,G,B}
- Red, Green, Blue  out  8 each  pixel colour
- blank_n_out  out  1  blank_n delayed to align with RGB
- frame_done  out  1  one-cycle pulse at each frame boundary
- hit_kirby_enemy, hit_star_enemy  out  1 each  previous frame's collision result, held until the next frame_done

Behaviour:
- Clock and reset: single clock Clk; Reset is synchronous, active-high.
- Reset values: all address outputs 0, RGB = 0, blank_n_out 0, frame_done 0, both hit outputs 0, sticky flags 0, pipeline valid/side-band registers 0, all palette entries 24'h000000.
- Pipeline, 3 stages, fixed latency 3 (no stalls):
  - S1 (edge 1): register all five indices onto the *_addr outputs. Register the side-band: in_win = (X_MIN<=DrawX<X_MAX && Y_MIN<=DrawY<Y_MAX), blank_n, sof = (DrawX==0 && DrawY==0), and a per-layer present flag (index!=0; star/enemy also ANDed with their active input).
  - S2 (edge 2): ROM codes arrive. Register the codes together with the side-band.
  - S3 (edge 3): drive RGB, blank_n_out, frame_done, hit outputs.
  - Pixel inputs at cycle N yield RGB at cycle N+3.
- Opacity: a layer is opaque iff its present flag is set and its code != TRANS_CODE. Background is always opaque. Index 0 of every sheet is reserved transparent.
- Priority, highest first: star, Kirby, enemy, area, background.
- Output colour:
  - !in_win -> BORDER_RGB.
  - !blank_n -> RGB = 0.
  - Otherwise RGB = palette[winning code].
- Palette: 16x24 register file, read combinationally in S3. A write commits at the clock edge. A same-cycle write to the entry being read returns the old value; the new value is visible from the next cycle.
- Collision:
  - At S3 of each in-window, active pixel, ke = kirby_opaque && enemy_opaque and se = star_opaque && enemy_opaque.
  - sticky_ke |= ke and sticky_se |= se.
- Frame boundary, when sof reaches S3:
  - frame_done = 1 for that cycle.
  - hit_kirby_enemy <= sticky_ke and hit_star_enemy <= sticky_se.
  - Sticky flags are loaded with that pixel's own ke/se; the prior frame's value is not lost.
- No other path clears the hit outputs except Reset.
- Reset mid-frame: every stage is flushed to reset values. Output resumes 3 cycles after deassertion. The first frame_done follows the next sof.
- Widths: addresses pass through unmodified with no truncation. Codes are 4-bit and index the palette directly.

Test Plan:
- Reset then idle → RGB=0, blank_n_out=0, hit outputs 0. With Reset held during stimulus, outputs stay 0.
- DrawX=100,DrawY=200,blank_n=1 → 3 clocks later RGB=BORDER_RGB. DrawX=300,DrawY=200 with all sprite indices 0, back_data=5, palette[5]=24'h123456 → RGB=12/34/56 at N+3; back_addr equals backindex at N+1.
- Priority: kirbyindex=40,kirby_data=3 and starindex=7,star_data=9,star_active=1 → palette[9]. Repeat with star_data=0 → palette[3]. Repeat with star_active=0 and star_data=9 → palette[3].
- Palette hazard: pal_we writes entry 3 = 24'hFF0000 in the same cycle S3 reads entry 3 (old 24'h00FF00) → that pixel outputs 00FF00; the next pixel outputs FF0000.
- Collision: one in-window pixel with kirby_data=2,enemy_data=4,enemy_active=1, then sof → frame_done pulse, hit_kirby_enemy=1, hit_star_enemy=0. A following frame with no overlap → next frame_done drives both hits to 0.
- blank_n=0 inside the window with opaque layers → RGB=0 and blank_n_out=0 at N+3. The overlap still sets the sticky flag only if blank_n=1; verify the flag does not set with blank_n=0.
